// File: rtl/amax10_qsys_onchip_mem_arbiter_pkg.sv
// Shared types for the two-requester on-chip RAM arbiter: requester id and the
// one-deep pending-read record that steers read data back to its requester.
package amax10_qsys_onchip_mem_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } pend_t;

endpackage

// File: rtl/amax10_qsys_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
// Zero latency; a losing requester sees no grant and must hold its request.
module amax10_qsys_rr_arb2
    import amax10_qsys_onchip_mem_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_vld,
    output req_id_t            gnt_id
);

    req_id_t prio;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = prio;
        if (en) begin
            unique case (req)
                2'b01: begin gnt_vld = 1'b1; gnt_id = 1'b0; end
                2'b10: begin gnt_vld = 1'b1; gnt_id = 1'b1; end
                2'b11: begin gnt_vld = 1'b1; gnt_id = prio; end
                default: ;
            endcase
        end
    end

    // The loser of this cycle becomes the favoured requester next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (gnt_vld) begin
            prio <= ~gnt_id;
        end
    end

endmodule

// File: rtl/amax10_qsys_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM requesters; reads return one
// enabled cycle after grant. Optional per-requester grant counters: AMAX10_ARB_PERF_CNT_EN.
module amax10_qsys_onchip_mem_arbiter
    import amax10_qsys_onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   r0_address,
    input  logic [DATA_W/8-1:0] r0_byteenable,
    input  logic                r0_read,
    input  logic                r0_write,
    input  logic [DATA_W-1:0]   r0_writedata,
    output logic                r0_waitrequest,
    output logic [DATA_W-1:0]   r0_readdata,
    output logic                r0_readdatavalid,
    input  logic [ADDR_W-1:0]   r1_address,
    input  logic [DATA_W/8-1:0] r1_byteenable,
    input  logic                r1_read,
    input  logic                r1_write,
    input  logic [DATA_W-1:0]   r1_writedata,
    output logic                r1_waitrequest,
    output logic [DATA_W-1:0]   r1_readdata,
    output logic                r1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
`ifdef AMAX10_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         grant_cnt0,
    output logic [31:0]         grant_cnt1
`endif
);

    logic [NUM_REQ-1:0] req;
    logic               arb_en;
    logic               gnt_vld;
    req_id_t            gnt_id;
    logic               rd_gnt;
    logic               rsp_fire;
    pend_t              pend;

    // A read+write collision counts as a write, so either strobe raises a request.
    assign req    = {r1_read | r1_write, r0_read | r0_write};
    assign arb_en = ~reset_req & ~reset;

    amax10_qsys_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .req     (req),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        mem_address    = gnt_id ? r1_address    : r0_address;
        mem_byteenable = gnt_id ? r1_byteenable : r0_byteenable;
        mem_writedata  = gnt_id ? r1_writedata  : r0_writedata;
        mem_chipselect = gnt_vld;
        mem_write      = gnt_vld & (gnt_id ? r1_write : r0_write);
    end

    assign r0_waitrequest = ~(gnt_vld & (gnt_id == 1'b0));
    assign r1_waitrequest = ~(gnt_vld & (gnt_id == 1'b1));
    assign mem_clken      = ~reset_req;

    assign rd_gnt   = gnt_vld & ~mem_write;
    assign rsp_fire = pend.vld & mem_clken;

    // RAM output register is frozen while clken is low, so a pending response
    // simply waits for the first enabled cycle and is then consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else if (rd_gnt) begin
            pend.vld <= 1'b1;
            pend.id  <= gnt_id;
        end else if (rsp_fire) begin
            pend.vld <= 1'b0;
        end
    end

    assign r0_readdatavalid = rsp_fire & (pend.id == 1'b0);
    assign r1_readdatavalid = rsp_fire & (pend.id == 1'b1);
    assign r0_readdata      = r0_readdatavalid ? mem_readdata : '0;
    assign r1_readdata      = r1_readdatavalid ? mem_readdata : '0;

`ifdef AMAX10_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (gnt_vld) begin
            if (gnt_id == 1'b0 && grant_cnt0 != 32'hFFFF_FFFF) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (gnt_id == 1'b1 && grant_cnt1 != 32'hFFFF_FFFF) grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_amax10_qsys_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter with a behavioural clock-enabled RAM.
module tb_amax10_qsys_onchip_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              reset_req;
    logic [ADDR_W-1:0] r0_address, r1_address;
    logic [3:0]        r0_byteenable, r1_byteenable;
    logic              r0_read, r0_write, r1_read, r1_write;
    logic [31:0]       r0_writedata, r1_writedata;
    logic              r0_waitrequest, r1_waitrequest;
    logic [31:0]       r0_readdata, r1_readdata;
    logic              r0_readdatavalid, r1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata = 32'h0;
`ifdef AMAX10_ARB_PERF_CNT_EN
    logic [31:0]       grant_cnt0, grant_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    amax10_qsys_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read),
        .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
        .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read),
        .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
        .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef AMAX10_ARB_PERF_CNT_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // Single-port RAM with registered output, frozen while clken is low; preloaded during reset.
    always @(posedge clk) begin
        if (reset) begin
            ram[16'h0010] <= 32'hDEADBEEF;
            ram[16'h0020] <= 32'h00000000;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
        r0_byteenable = 4'hF; r1_byteenable = 4'hF;
    endtask

    initial begin
        reset = 1'b1; reset_req = 1'b0;
        idle();
        r0_address = '0; r1_address = '0; r0_writedata = '0; r1_writedata = '0;
        // Request present during reset must not be granted.
        r0_read = 1; r0_address = 16'h0010;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_wait0", {31'b0, r0_waitrequest}, 32'd1);
        chk("rst_wait1", {31'b0, r1_waitrequest}, 32'd1);
        chk("rst_cs", {31'b0, mem_chipselect}, 32'd0);
        chk("rst_wr", {31'b0, mem_write}, 32'd0);
        chk("rst_rdv", {30'b0, r1_readdatavalid, r0_readdatavalid}, 32'd0);
        chk("rst_clken", {31'b0, mem_clken}, 32'd1);

        // Single read, first cycle after release.
        tick(); reset = 1'b0; #3;
        chk("rd_wait0", {31'b0, r0_waitrequest}, 32'd0);
        chk("rd_wait1", {31'b0, r1_waitrequest}, 32'd1);
        chk("rd_cs", {31'b0, mem_chipselect}, 32'd1);
        chk("rd_addr", {16'b0, mem_address}, 32'h0010);
        tick(); idle(); #3;
        chk("rd_rdv", {31'b0, r0_readdatavalid}, 32'd1);
        chk("rd_data", r0_readdata, 32'hDEADBEEF);
        chk("rd_rdv1", {31'b0, r1_readdatavalid}, 32'd0);
        tick(); #3;
        chk("rd_rdv_once", {31'b0, r0_readdatavalid}, 32'd0);
        chk("rd_data_zero", r0_readdata, 32'd0);

        // Reset one cycle after an r1 read grant: response discarded.
        tick(); r1_read = 1; r1_address = 16'h0010; #3;
        chk("rmid_grant1", {31'b0, r1_waitrequest}, 32'd0);
        tick(); idle(); reset = 1'b1; #3;
        chk("rmid_rdv_in", {31'b0, r1_readdatavalid}, 32'd0);
        tick(); reset = 1'b0; #3;
        chk("rmid_rdv_out", {30'b0, r1_readdatavalid, r0_readdatavalid}, 32'd0);

        // Both write continuously: r0 first, then alternating.
        tick();
        r0_write = 1; r0_address = 16'h0040; r0_writedata = 32'h11111111;
        r1_write = 1; r1_address = 16'h0041; r1_writedata = 32'h22222222;
        for (int c = 0; c < 4; c++) begin
            #3;
            chk($sformatf("alt_wait0_c%0d", c), {31'b0, r0_waitrequest}, (c % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("alt_wait1_c%0d", c), {31'b0, r1_waitrequest}, (c % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt_wr_c%0d", c), {31'b0, mem_write}, 32'd1);
            tick();
        end
        idle(); #3;
        chk("alt_no_rdv", {30'b0, r1_readdatavalid, r0_readdatavalid}, 32'd0);
        chk("idle_cs", {30'b0, mem_write, mem_chipselect}, 32'd0);

        // Byte-lane write then read back.
        tick();
        r1_write = 1; r1_address = 16'h0020; r1_writedata = 32'h11223344; r1_byteenable = 4'b0100; #3;
        chk("be_grant", {31'b0, r1_waitrequest}, 32'd0);
        chk("be_mask", {28'b0, mem_byteenable}, 32'h4);
        tick(); idle(); r1_read = 1; #3;
        chk("be_rd_grant", {31'b0, r1_waitrequest}, 32'd0);
        tick(); idle(); #3;
        chk("be_rdv", {31'b0, r1_readdatavalid}, 32'd1);
        chk("be_data", r1_readdata, 32'h00220000);

        // Read-then-write same address, then back-to-back reads.
        tick(); r0_read = 1; r0_address = 16'h0040; #3;
        chk("rw_rd_grant", {31'b0, r0_waitrequest}, 32'd0);
        tick(); idle(); r1_write = 1; r1_address = 16'h0040; r1_writedata = 32'h00000055; #3;
        chk("rw_old_rdv", {31'b0, r0_readdatavalid}, 32'd1);
        chk("rw_old_data", r0_readdata, 32'h11111111);
        chk("rw_wr_grant", {31'b0, r1_waitrequest}, 32'd0);
        tick(); idle(); r0_read = 1; r0_address = 16'h0040; #3;
        chk("rw_wr_no_rdv", {30'b0, r1_readdatavalid, r0_readdatavalid}, 32'd0);
        tick(); r1_read = 1; r0_address = 16'h0010; r1_address = 16'h0020; #3;
        chk("b2b_wait1", {31'b0, r1_waitrequest}, 32'd0);
        chk("b2b_wait0", {31'b0, r0_waitrequest}, 32'd1);
        chk("b2b_new_data", r0_readdata, 32'h00000055);
        tick(); r1_read = 0; #3;
        chk("b2b_wait0b", {31'b0, r0_waitrequest}, 32'd0);
        chk("b2b_rdv1", {31'b0, r1_readdatavalid}, 32'd1);
        chk("b2b_data1", r1_readdata, 32'h00220000);
        tick(); idle(); #3;
        chk("b2b_rdv0", {31'b0, r0_readdatavalid}, 32'd1);
        chk("b2b_data0", r0_readdata, 32'hDEADBEEF);

        // reset_req pulse holding a pending read response.
        tick(); r0_read = 1; r0_address = 16'h0010; #3;
        chk("rr_grant", {31'b0, r0_waitrequest}, 32'd0);
        tick(); idle(); reset_req = 1; r1_read = 1; r1_address = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("rr_clken_c%0d", c), {31'b0, mem_clken}, 32'd0);
            chk($sformatf("rr_nogrant_c%0d", c), {30'b0, mem_chipselect, ~r1_waitrequest}, 32'd0);
            chk($sformatf("rr_hold_c%0d", c), {31'b0, r0_readdatavalid}, 32'd0);
            tick();
        end
        reset_req = 0; #3;
        chk("rr_rdv", {31'b0, r0_readdatavalid}, 32'd1);
        chk("rr_data", r0_readdata, 32'hDEADBEEF);
        chk("rr_r1_grant", {31'b0, r1_waitrequest}, 32'd0);
        tick(); idle(); #3;
        chk("rr_rdv_once", {31'b0, r0_readdatavalid}, 32'd0);
        chk("rr_r1_rdv", {31'b0, r1_readdatavalid}, 32'd1);
        chk("rr_r1_data", r1_readdata, 32'h00220000);

`ifdef AMAX10_ARB_PERF_CNT_EN
        chk("cnt0", grant_cnt0, 32'd6);
        chk("cnt1", grant_cnt1, 32'd7);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/amax10_qsys_onchip_mem_arbiter.md
AMAX10_QSYS_ONCHIP_MEM_ARBITER -- requirements
Module: amax10_qsys_onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width of the shared single-port RAM.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Port clk  in  1  the only clock; all logic is rising-edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port reset_req  in  1  RAM clock-enable suppression request.
REQ-006 Ports rN_address  in  ADDR_W, rN_byteenable  in  DATA_W/8, rN_read  in  1, rN_write  in  1, rN_writedata  in  DATA_W (N=0,1)  Avalon-MM requester commands.
REQ-007 Ports rN_waitrequest  out  1, rN_readdata  out  DATA_W, rN_readdatavalid  out  1  (N=0,1)  per-requester responses.
REQ-008 Ports mem_address  out  ADDR_W, mem_byteenable  out  DATA_W/8, mem_chipselect  out  1, mem_write  out  1, mem_writedata  out  DATA_W, mem_clken  out  1  RAM command.
REQ-009 Port mem_readdata  in  DATA_W  RAM output; valid one enabled cycle after the read command.

Function
REQ-010 The requester command is valid when rN_read | rN_write; rN_read and rN_write both high is a protocol error, and the request is treated as a write.
REQ-011 At most one command is issued to the RAM per cycle.
REQ-012 The grant is combinational in the same cycle from current requests and the registered priority pointer prio (0 or 1).
REQ-013 Only one requester valid: that requester is granted.
REQ-014 Both requesters valid: requester prio is granted.
REQ-015 After any grant, prio becomes the non-granted index (round-robin).
REQ-016 With no grant, prio holds.
REQ-017 Granted requester: rN_waitrequest=0.
REQ-018 A valid requester that is not granted gets rN_waitrequest=1 and must hold its command stable.
REQ-019 An idle requester gets rN_waitrequest=1.
REQ-020 On a grant: mem_chipselect=1; address, byteenable, writedata and write are driven from the granted requester.
REQ-021 With no grant, mem_chipselect=0 and mem_write=0.
REQ-022 mem_clken = ~reset_req.
REQ-023 While reset_req=1: no grants, both waitrequests=1, and prio holds.
REQ-024 A granted read sets a one-deep pending register {pend_valid, pend_id}.
REQ-025 On the next cycle with mem_clken=1, rN_readdatavalid=1 pulses for 1 cycle for requester pend_id, with rN_readdata=mem_readdata.
REQ-026 rN_readdata is don't-care when not valid and is driven 0.
REQ-027 If reset_req rises while pend_valid=1, the response is held and issued on the first cycle reset_req=0; it is never dropped or duplicated.
REQ-028 Back-to-back reads, including alternating requesters, sustain 1 read per cycle, with responses in grant order.
REQ-029 A write completes on its grant cycle and produces no readdatavalid.
REQ-030 A read and a write to the same address in consecutive cycles return pre-write data for the read issued first.

Reset
REQ-031 On reset assertion, asynchronously: prio=0, pend_valid=0, pend_id=0, and the counters (if present) are cleared.
REQ-032 Outputs during reset: waitrequests=1, readdatavalids=0, mem_chipselect=0, mem_write=0.
REQ-033 A read in flight at reset is discarded.
REQ-034 Reset deassertion is synchronised externally; the first grant is possible on the first clk edge after release.

Configuration
REQ-035 Macro AMAX10_ARB_PERF_CNT_EN defined: adds output ports grant_cnt0 and grant_cnt1 (32 bits each), saturating counts of grants per requester.
REQ-036 Macro AMAX10_ARB_PERF_CNT_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Structure
REQ-037 A shared package holds the requester-id type (1 bit), NUM_REQ=2, and the pending-read record type.
REQ-038 One sub-module, amax10_qsys_rr_arb2, holds the two-input round-robin grant and prio register; the read-return path stays at top level.

Verification
REQ-039 Single read, no contention: r0 read at addr 0x0010 (RAM holds 0xDEADBEEF) -> r0_waitrequest=0 in the same cycle; next cycle r0_readdatavalid=1 with 0xDEADBEEF.
REQ-040 Simultaneous continuous writes from r0 and r1 after reset -> grants alternate r0,r1,r0,r1; each waitrequest is low every other cycle.
REQ-041 Byte write: r1 write 0x11223344, byteenable 0b0100 to a word holding 0 -> subsequent read returns 0x00220000.
REQ-042 reset_req pulse: r0 read granted, reset_req=1 for 3 cycles on the next edge -> no grant during the pulse; r0_readdatavalid fires exactly once, on the first cycle after reset_req falls.
REQ-043 Reset mid-read: assert reset the cycle after an r1 read grant -> no r1_readdatavalid; prio=0 after release.
REQ-044 With AMAX10_ARB_PERF_CNT_EN defined: 5 r0 grants and 3 r1 grants -> grant_cnt0=5, grant_cnt1=3.
